// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolver and its in-flight queue.
package branch_pkg;

   // Widest PC any instance may use; entries carry this width and each
   // instance keeps only its own ADDR_W low bits.
   localparam int unsigned BR_PC_MAX_W = 64;

   // Training-update code presented to the predictor.
   localparam logic [1:0] BR_COND_NONE = 2'b00;
   localparam logic [1:0] BR_COND_UPD  = 2'b01;

   // Fall-through distance for a not-taken branch.
   localparam int unsigned PC_STEP = 4;

   // One in-flight conditional branch.
   typedef struct packed {
      logic [BR_PC_MAX_W-1:0] pc;
      logic [BR_PC_MAX_W-1:0] target;
      logic                   pred;
   } br_entry_t;

   // Saturating 16-bit increment.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/br_inflight_fifo.sv
// In-order queue of unresolved branch predictions with synchronous clear.
module br_inflight_fifo
   import branch_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_clear,
   input  br_entry_t                i_entry,
   output br_entry_t                o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   br_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic      w_full;
   logic      w_empty;
   logic      w_do_pop;
   logic      w_do_push;
   br_entry_t w_wr_entry;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);

   // A pop frees the head slot in the same cycle, so a push is accepted
   // when full provided a pop happens alongside it.
   assign w_do_pop  = i_pop && !w_empty && !i_clear;
   assign w_do_push = i_push && (!w_full || w_do_pop) && !i_clear;

   // Keep only the instance's PC width; upper bits stored as zero.
   always_comb begin
      w_wr_entry        = i_entry;
      w_wr_entry.pc     = BR_PC_MAX_W'(ADDR_W'(i_entry.pc));
      w_wr_entry.target = BR_PC_MAX_W'(ADDR_W'(i_entry.target));
   end

   // Pointer and occupancy tracking; clear empties the queue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_do_push && w_do_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= w_wr_entry;
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_count = r_count;

endmodule

// File: rtl/branch_resolver.sv
// Tracks in-flight branch predictions, compares them with execute outcomes,
// trains the predictor and raises flush/redirect on a mispredict.
// Optional resolution/mispredict counters: define BRANCH_RESOLVER_STATS_EN.
module branch_resolver
   import branch_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rstn_h,
   input  logic              pred_valid,
   input  logic              pred_taken_in,
   input  logic [ADDR_W-1:0] pred_pc,
   input  logic [ADDR_W-1:0] pred_target,
   input  logic              res_valid,
   input  logic              res_taken,
   output logic              act_taken,
   output logic              pred_taken,
   output logic [1:0]        branch_cond,
   output logic              flush,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              full,
   output logic              empty,
   output logic              err
`ifdef BRANCH_RESOLVER_STATS_EN
   ,
   output logic [15:0]       stat_resolved,
   output logic [15:0]       stat_mispred
`endif
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   br_entry_t         w_head;
   br_entry_t         w_push_entry;
   logic              w_full;
   logic              w_empty;
   logic [CNT_W-1:0]  w_count_unused;
   logic              w_res_ok;
   logic              w_mispred;
   logic              w_pop;
   logic              w_push;
   logic              w_err_set;
   logic [ADDR_W-1:0] w_head_pc;
   logic [ADDR_W-1:0] w_head_target;
   logic [ADDR_W-1:0] w_redirect;

   logic              r_act_taken;
   logic              r_pred_taken;
   logic [1:0]        r_branch_cond;
   logic              r_flush;
   logic [ADDR_W-1:0] r_redirect_pc;
   logic              r_err;

   // Entry assembled from the predictor's request.
   always_comb begin
      w_push_entry        = '0;
      w_push_entry.pc     = BR_PC_MAX_W'(pred_pc);
      w_push_entry.target = BR_PC_MAX_W'(pred_target);
      w_push_entry.pred   = pred_taken_in;
   end

   // Resolve/mispredict decode; a mispredict discards everything younger,
   // including a push arriving in the same cycle.
   always_comb begin
      w_res_ok  = res_valid && !w_empty;
      w_mispred = w_res_ok && (res_taken != w_head.pred);
      w_pop     = w_res_ok && !w_mispred;
      w_push    = pred_valid && !w_mispred;
      w_err_set = (res_valid && w_empty) || (pred_valid && w_full && !w_res_ok);
   end

   // Correct next PC for the head branch given its actual outcome.
   always_comb begin
      w_head_pc     = ADDR_W'(w_head.pc);
      w_head_target = ADDR_W'(w_head.target);
      w_redirect    = res_taken ? w_head_target : (w_head_pc + ADDR_W'(PC_STEP));
   end

   br_inflight_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rstn_h),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_clear (w_mispred),
      .i_entry (w_push_entry),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count_unused)
   );

   // Predictor training outputs, one-cycle update strobe.
   always_ff @(posedge clk or posedge rstn_h) begin
      if (rstn_h) begin
         r_act_taken   <= 1'b0;
         r_pred_taken  <= 1'b0;
         r_branch_cond <= BR_COND_NONE;
      end else if (w_res_ok) begin
         r_act_taken   <= res_taken;
         r_pred_taken  <= w_head.pred;
         r_branch_cond <= BR_COND_UPD;
      end else begin
         r_branch_cond <= BR_COND_NONE;
      end
   end

   // Flush pulse and redirect target; redirect holds between mispredicts.
   always_ff @(posedge clk or posedge rstn_h) begin
      if (rstn_h) begin
         r_flush       <= 1'b0;
         r_redirect_pc <= '0;
      end else begin
         r_flush <= w_mispred;
         if (w_mispred) begin
            r_redirect_pc <= w_redirect;
         end
      end
   end

   // Sticky protocol-error flag: overflowing push or resolve on empty.
   always_ff @(posedge clk or posedge rstn_h) begin
      if (rstn_h) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end
   end

`ifdef BRANCH_RESOLVER_STATS_EN
   logic [15:0] r_stat_resolved;
   logic [15:0] r_stat_mispred;

   // Saturating resolution and mispredict counters.
   always_ff @(posedge clk or posedge rstn_h) begin
      if (rstn_h) begin
         r_stat_resolved <= '0;
         r_stat_mispred  <= '0;
      end else if (w_res_ok) begin
         r_stat_resolved <= sat_inc16(r_stat_resolved);
         if (w_mispred) begin
            r_stat_mispred <= sat_inc16(r_stat_mispred);
         end
      end
   end

   assign stat_resolved = r_stat_resolved;
   assign stat_mispred  = r_stat_mispred;
`endif

   assign act_taken   = r_act_taken;
   assign pred_taken  = r_pred_taken;
   assign branch_cond = r_branch_cond;
   assign flush       = r_flush;
   assign redirect_pc = r_redirect_pc;
   assign full        = w_full;
   assign empty       = w_empty;
   assign err         = r_err;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed pushes/resolves with
// hand-computed expectations checked by an independent output monitor.
module tb_branch_resolver;

   localparam int unsigned ADDR_W = 32;

   typedef struct {
      logic        act;
      logic        pred;
      logic        fl;
      logic [31:0] redir;
   } exp_t;

   logic              clk;
   logic              rstn_h;
   logic              pred_valid;
   logic              pred_taken_in;
   logic [ADDR_W-1:0] pred_pc;
   logic [ADDR_W-1:0] pred_target;
   logic              res_valid;
   logic              res_taken;
   logic              act_taken;
   logic              pred_taken;
   logic [1:0]        branch_cond;
   logic              flush;
   logic [ADDR_W-1:0] redirect_pc;
   logic              full;
   logic              empty;
   logic              err;
`ifdef BRANCH_RESOLVER_STATS_EN
   logic [15:0]       stat_resolved;
   logic [15:0]       stat_mispred;
`endif

   int   n_vec  = 0;
   int   n_miss = 0;
   exp_t sb_q[$];

   branch_resolver #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .rstn_h        (rstn_h),
      .pred_valid    (pred_valid),
      .pred_taken_in (pred_taken_in),
      .pred_pc       (pred_pc),
      .pred_target   (pred_target),
      .res_valid     (res_valid),
      .res_taken     (res_taken),
      .act_taken     (act_taken),
      .pred_taken    (pred_taken),
      .branch_cond   (branch_cond),
      .flush         (flush),
      .redirect_pc   (redirect_pc),
      .full          (full),
      .empty         (empty),
      .err           (err)
`ifdef BRANCH_RESOLVER_STATS_EN
      ,
      .stat_resolved (stat_resolved),
      .stat_mispred  (stat_mispred)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock with the given stimulus, then return to idle just after the edge.
   task automatic step(input logic pv, input logic pt, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic rv, input logic rt);
      pred_valid    = pv;
      pred_taken_in = pt;
      pred_pc       = pc;
      pred_target   = tgt;
      res_valid     = rv;
      res_taken     = rt;
      @(posedge clk);
      #1;
      pred_valid = 1'b0;
      res_valid  = 1'b0;
   endtask

   task automatic push(input logic pt, input logic [31:0] pc, input logic [31:0] tgt);
      step(1'b1, pt, pc, tgt, 1'b0, 1'b0);
   endtask

   task automatic expect_res(input logic a, input logic p, input logic f, input logic [31:0] r);
      exp_t e;
      e.act = a; e.pred = p; e.fl = f; e.redir = r;
      sb_q.push_back(e);
   endtask

   // Monitor: every update strobe must match the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rstn_h) begin
            if (branch_cond == 2'b01) begin
               if (sb_q.size() == 0) begin
                  n_vec++;
                  n_miss++;
                  $display("FAIL unexpected_update: got branch_cond=%b, expected none", branch_cond);
               end else begin
                  e = sb_q.pop_front();
                  check("act_taken",   64'(act_taken),   64'(e.act));
                  check("pred_taken",  64'(pred_taken),  64'(e.pred));
                  check("flush",       64'(flush),       64'(e.fl));
                  check("redirect_pc", 64'(redirect_pc), 64'(e.redir));
               end
            end else begin
               check("idle_branch_cond", 64'(branch_cond), 64'd0);
               check("idle_flush",       64'(flush),       64'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn_h = 1'b1;
      pred_valid = 1'b0; pred_taken_in = 1'b0; pred_pc = '0; pred_target = '0;
      res_valid = 1'b0; res_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn_h = 1'b0;

      // Reset state
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_full",  64'(full),  64'd0);
      check("rst_err",   64'(err),   64'd0);
      check("rst_redir", 64'(redirect_pc), 64'd0);
      check("rst_act",   64'(act_taken),   64'd0);
      check("rst_pred",  64'(pred_taken),  64'd0);

      // Resolve while empty: error, no update strobe
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      check("empty_res_err",  64'(err),         64'd1);
      check("empty_res_cond", 64'(branch_cond), 64'd0);
`ifdef BRANCH_RESOLVER_STATS_EN
      check("empty_res_stat", 64'(stat_resolved), 64'd0);
`endif

      // Asynchronous reset with three entries queued
      push(1'b1, 32'h10, 32'h20);
      push(1'b0, 32'h14, 32'h24);
      push(1'b1, 32'h18, 32'h28);
      check("pre_rst_empty", 64'(empty), 64'd0);
      #2 rstn_h = 1'b1;
      #1;
      check("async_rst_empty", 64'(empty), 64'd1);
      check("async_rst_full",  64'(full),  64'd0);
      check("async_rst_err",   64'(err),   64'd0);
      check("async_rst_cond",  64'(branch_cond), 64'd0);
      @(posedge clk);
      #1 rstn_h = 1'b0;

      // Correct prediction, taken
      push(1'b1, 32'h100, 32'h200);
      expect_res(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      check("correct_empty", 64'(empty), 64'd1);

      // Mispredict, not taken: redirect to pc+4 and drop younger entry
      push(1'b1, 32'h100, 32'h200);
      push(1'b0, 32'h104, 32'h300);
      expect_res(1'b0, 1'b1, 1'b1, 32'h104);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("mis_nt_empty", 64'(empty), 64'd1);

      // Mispredict, taken: redirect to target
      push(1'b0, 32'h300, 32'h80);
      expect_res(1'b1, 1'b0, 1'b1, 32'h80);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      check("mis_t_empty", 64'(empty), 64'd1);

      // Correct not-taken: redirect holds
      push(1'b0, 32'h400, 32'h500);
      expect_res(1'b0, 1'b0, 1'b0, 32'h80);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Fill to DEPTH
      push(1'b1, 32'h10, 32'h1000);
      push(1'b0, 32'h20, 32'h1100);
      push(1'b1, 32'h30, 32'h1200);
      check("not_yet_full", 64'(full), 64'd0);
      push(1'b1, 32'h40, 32'h1300);
      check("full_set",  64'(full), 64'd1);
      check("full_err0", 64'(err),  64'd0);

      // Push alongside a correct resolve while full
      expect_res(1'b1, 1'b1, 1'b0, 32'h80);
      step(1'b1, 1'b0, 32'h60, 32'h2000, 1'b1, 1'b1);
      check("full_swap_full", 64'(full), 64'd1);
      check("full_swap_err",  64'(err),  64'd0);

      // Overflow push is dropped and flags an error
      push(1'b1, 32'h50, 32'h3000);
      check("overflow_err",  64'(err),  64'd1);
      check("overflow_full", 64'(full), 64'd1);

      // Drain in order; last entry is the swapped-in 0x60, not the dropped 0x50
      expect_res(1'b0, 1'b0, 1'b0, 32'h80);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("drain_not_full", 64'(full), 64'd0);
      expect_res(1'b1, 1'b1, 1'b0, 32'h80);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      expect_res(1'b1, 1'b1, 1'b0, 32'h80);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      expect_res(1'b1, 1'b0, 1'b1, 32'h2000);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      check("drain_empty", 64'(empty), 64'd1);

      // Mispredict with a same-cycle push: the push is discarded too
      push(1'b1, 32'h700, 32'h800);
      expect_res(1'b0, 1'b1, 1'b1, 32'h704);
      step(1'b1, 1'b0, 32'h900, 32'hA00, 1'b1, 1'b0);
      check("mis_push_empty", 64'(empty), 64'd1);

      // Fall-through wraps modulo 2^ADDR_W
      push(1'b1, 32'hFFFF_FFFC, 32'h1234);
      expect_res(1'b0, 1'b1, 1'b1, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      check("wrap_empty", 64'(empty), 64'd1);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      check("err_sticky", 64'(err), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
